// File: rtl/cnn_pkg.sv
// Shared convolution-datapath definitions: window state encoding, default
// operand widths and the filter bias shared with quantization and ReLU.
package cnn_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_BIAS,
    ST_OUT
  } state_t;

  localparam int unsigned DEF_TAPS  = 9;
  localparam int unsigned DEF_ACT_W = 17;
  localparam int unsigned DEF_WGT_W = 16;
  localparam int unsigned DEF_ACC_W = 32;
  localparam int          DEF_BIAS  = -843;

endpackage

// File: rtl/conv_sat_add.sv
// Signed W-bit adder for the window accumulator.
// CONV_ACC_SAT_EN: when defined the sum clamps to the signed W-bit range,
// otherwise it wraps modulo 2^W.
module conv_sat_add #(
  parameter int unsigned W = 32
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum
);

`ifdef CONV_ACC_SAT_EN
  logic signed [W:0] w_wide;

  // One guard bit exposes overflow; a disagreeing top pair means clamp.
  always_comb begin
    w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    o_sum  = w_wide[W-1:0];
    if (w_wide[W] != w_wide[W-1]) begin
      o_sum = w_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Plain two's-complement wrap.
  always_comb begin
    o_sum = i_a + i_b;
  end
`endif

endmodule

// File: rtl/conv_window_acc.sv
// Convolution window accumulator: takes TAPS activation/weight pairs,
// registers each product, accumulates, adds the filter bias and presents the
// sign-extended sum to quantization.
// CONV_ACC_SAT_EN (in conv_sat_add) selects saturating accumulation.
module conv_window_acc
  import cnn_pkg::*;
#(
  parameter int unsigned TAPS  = DEF_TAPS,
  parameter int unsigned ACT_W = DEF_ACT_W,
  parameter int unsigned WGT_W = DEF_WGT_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int          BIAS  = DEF_BIAS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACT_W-1:0] act,
  input  logic signed [WGT_W-1:0] wgt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [63:0]             acc_out
);

  localparam int unsigned PROD_W = ACT_W + WGT_W;
  localparam int unsigned CNT_W  = (TAPS > 1) ? $clog2(TAPS + 1) : 1;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          r_tap_cnt;
  logic signed [PROD_W-1:0]  r_prod;
  logic                      r_prod_vld;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   w_add_b;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_accept;

  assign w_accept = in_valid && (r_state == ST_ACCUM);

  // Single adder: bias step borrows it, otherwise it takes the product
  // (sign-extended or truncated to the accumulator width).
  assign w_add_b = (r_state == ST_BIAS) ? ACC_W'(BIAS) : ACC_W'(r_prod);

  conv_sat_add #(.W(ACC_W)) u_add (
    .i_a   (r_acc),
    .i_b   (w_add_b),
    .o_sum (w_sum)
  );

  assign acc_out = 64'(r_acc);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_ACCUM;
    else      r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs, both decoded from registered state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (r_tap_cnt == CNT_W'(TAPS - 1))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_BIAS;
      ST_BIAS:  w_state_nxt = ST_OUT;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACCUM;
      end
      default:  w_state_nxt = ST_ACCUM;
    endcase
  end

  // Product register, tap counter and accumulator.
  // prod_vld follows each accept for exactly one cycle so a stalled input
  // never re-adds the same product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_tap_cnt  <= '0;
      r_acc      <= '0;
    end else begin
      r_prod_vld <= w_accept;
      if (w_accept) begin
        r_prod    <= PROD_W'(act) * PROD_W'(wgt);
        r_tap_cnt <= r_tap_cnt + CNT_W'(1);
      end
      if ((r_state == ST_OUT) && out_ready) begin
        r_acc      <= '0;
        r_tap_cnt  <= '0;
        r_prod_vld <= 1'b0;
      end else if ((r_state == ST_BIAS) || r_prod_vld) begin
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_acc.sv
// Directed bench for conv_window_acc with hand-computed window results.
module tb_conv_window_acc;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] act;
  logic signed [15:0] wgt;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        acc_out;

  int vectors;
  int miscompares;

  conv_window_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .wgt       (wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present n pairs; optionally leave every other cycle idle. The last
  // accept happens on the posedge following return.
  task automatic drive_pairs(input logic signed [16:0] a, input logic signed [15:0] w,
                             input int n, input bit gaps, output bit early_ov, output int cycles);
    int cnt;
    bit tog;
    cnt = 0; tog = 1'b0; early_ov = 1'b0; cycles = 0;
    while (cnt < n && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (out_valid) early_ov = 1'b1;
      act = a; wgt = w;
      in_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      if (in_valid && in_ready) cnt++;
    end
  endtask

  // Count negedges from the last accept until out_valid (bounded) and note
  // whether in_ready stayed low meanwhile.
  task automatic wait_result(output int lat, output logic [63:0] res, output bit rdy_low);
    lat = 0; rdy_low = 1'b1; res = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (in_ready) rdy_low = 1'b0;
      if (out_valid) break;
    end
    res = acc_out;
  endtask

  task automatic pulse_out_ready();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; act = '0; wgt = '0;
    #3;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 64'd0) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b acc_out=%h, want 1 0 0", in_ready, out_valid, acc_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unit_window();
    bit e; int c, lat; logic [63:0] r; bit rl;
    drive_pairs(17'sd1, 16'sd1, 9, 1'b0, e, c);
    wait_result(lat, r, rl);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FCBE) begin
      miscompares++; $display("FAIL unit_result: acc_out=%h want FFFFFFFFFFFFFCBE", r);
    end
    vectors++;
    if (lat !== 3) begin
      miscompares++; $display("FAIL unit_latency: out_valid after %0d edges want 3", lat);
    end
    pulse_out_ready();
  endtask

  task automatic test_mixed_signs();
    bit e; int c, lat; logic [63:0] r; bit rl;
    drive_pairs(-17'sd3, 16'sd5, 9, 1'b0, e, c);
    wait_result(lat, r, rl);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FC2E) begin
      miscompares++; $display("FAIL mixed_result: acc_out=%h want -978 (..FC2E)", r);
    end
    vectors++;
    if (rl !== 1'b1) begin
      miscompares++; $display("FAIL mixed_ready_low: in_ready rose during DRAIN/BIAS/OUT, want 0");
    end
    pulse_out_ready();
  endtask

  task automatic test_backpressure();
    bit e; int c, lat; logic [63:0] r; bit rl, stable;
    drive_pairs(17'sd1, 16'sd1, 9, 1'b0, e, c);
    wait_result(lat, r, rl);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 64'hFFFF_FFFF_FFFF_FCBE) stable = 1'b0;
    end
    vectors++;
    if (stable !== 1'b1) begin
      miscompares++; $display("FAIL bp_hold: out_valid=%b in_ready=%b acc_out=%h want 1 0 ..FCBE held", out_valid, in_ready, acc_out);
    end
    pulse_out_ready();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 64'd0) begin
      miscompares++; $display("FAIL bp_release: out_valid=%b in_ready=%b acc_out=%h want 0 1 0", out_valid, in_ready, acc_out);
    end
  endtask

  task automatic test_gaps();
    bit e; int c, lat; logic [63:0] r; bit rl;
    drive_pairs(17'sd1, 16'sd1, 9, 1'b1, e, c);
    wait_result(lat, r, rl);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FCBE || e !== 1'b0) begin
      miscompares++; $display("FAIL gaps_result: acc_out=%h early=%b want ..FCBE early=0", r, e);
    end
    vectors++;
    if (c !== 18) begin
      miscompares++; $display("FAIL gaps_cycles: %0d cycles to present 9 pairs, want 18", c);
    end
    pulse_out_ready();
  endtask

  task automatic test_reset_mid_window();
    bit e; int c, lat; logic [63:0] r; bit rl;
    drive_pairs(17'sd1, 16'sd1, 5, 1'b0, e, c);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 64'd0) begin
      miscompares++; $display("FAIL midrst_outputs: in_ready=%b out_valid=%b acc_out=%h want 1 0 0", in_ready, out_valid, acc_out);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    drive_pairs(17'sd1, 16'sd1, 9, 1'b0, e, c);
    wait_result(lat, r, rl);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FCBE || lat !== 3) begin
      miscompares++; $display("FAIL midrst_next: acc_out=%h lat=%0d want ..FCBE lat=3", r, lat);
    end
    pulse_out_ready();
  endtask

  task automatic test_overflow();
    bit e; int c, lat; logic [63:0] r; bit rl; logic [63:0] exp_v;
`ifdef CONV_ACC_SAT_EN
    exp_v = 64'd2147482804;
`else
    exp_v = 64'd2146598078;
`endif
    drive_pairs(17'sd65535, 16'sd32767, 9, 1'b0, e, c);
    wait_result(lat, r, rl);
    vectors++;
    if (r !== exp_v) begin
      miscompares++; $display("FAIL overflow: acc_out=%0d want %0d", r, exp_v);
    end
    pulse_out_ready();
  endtask

  // out_ready tied high, input always valid: one result every 12 cycles.
  task automatic test_back_to_back();
    int hits[$];
    bit bad_val;
    bad_val = 1'b0;
    @(negedge clk);
    act = 17'sd1; wgt = 16'sd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (out_valid) begin
        hits.push_back(i);
        if (acc_out !== 64'hFFFF_FFFF_FFFF_FCBE) bad_val = 1'b1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (hits.size() !== 2 || bad_val) begin
      miscompares++; $display("FAIL b2b_results: %0d results bad_val=%b want 2 of ..FCBE", hits.size(), bad_val);
    end else begin
      vectors++;
      if (hits[0] !== 11 || hits[1] - hits[0] !== 12) begin
        miscompares++; $display("FAIL b2b_period: first at %0d period %0d want 11 and 12", hits[0], hits[1] - hits[0]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_unit_window();
    test_mixed_signs();
    test_backpressure();
    test_gaps();
    test_reset_mid_window();
    test_overflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_window_acc.md
# conv_window_acc

Upstream accumulation stage of the convolution datapath. Accepts one filter window of TAPS signed activation/weight pairs over a valid/ready stream, forms registered products, accumulates them, and adds the filter bias. Presents the signed sum, sign-extended to 64 bits, to the quantization stage, which feeds ReLU.

## Interface
- TAPS, 9, products per window (3x3 kernel)
- ACT_W, 17, signed activation width
- WGT_W, 16, signed weight width
- ACC_W, 32, signed accumulator width
- BIAS, -843, signed filter bias added once per window
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  reset, asynchronous and active-low
- in_valid  in  1  activation/weight pair valid
- in_ready  out  1  stage can accept a pair
- act  in  ACT_W  signed activation
- wgt  in  WGT_W  signed weight
- out_valid  out  1  window result valid
- out_ready  in  1  quantization stage accepts result
- acc_out  out  64  signed result, sign-extended from ACC_W

## Operation
- States: ACCUM, DRAIN, BIAS, OUT.
- Reset (rst=0, asynchronous) forces:
  - state=ACCUM, acc=0, tap_cnt=0, prod_vld=0, prod_r=0
  - outputs: in_ready=1, out_valid=0, acc_out=0
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: prod_r←act*wgt, as a full (ACT_W+WGT_W)-bit signed product; prod_vld←1; tap_cnt++.
  - The cycle after each accept: acc←acc+sext(prod_r).
  - The accept that brings tap_cnt to TAPS moves to DRAIN.
  - Gaps in in_valid stall counting; no timeout.
- DRAIN (1 cycle): in_ready=0; last product is added to acc; go to BIAS.
- BIAS (1 cycle): acc←acc+sext(BIAS); go to OUT.
- OUT:
  - out_valid=1; acc_out=sext64(acc), held stable until accepted.
  - On out_ready: acc←0, tap_cnt←0, prod_vld←0; go to ACCUM.
- Arithmetic:
  - Product is ACT_W+WGT_W bits, truncated to ACC_W only if wider.
  - All adds are two's complement in ACC_W bits; overflow behaviour is set by Configuration.
- Boundary conditions:
  - in_valid while in_ready=0 is ignored; no pair is lost because the source must hold it.
  - out_ready while out_valid=0 has no effect.
  - Reset mid-window discards partial sums; the next window starts from tap 0.
  - TAPS=1 is legal: ACCUM→DRAIN on the first accept.

## Timing
- Product register: 1 cycle. Accumulate: 1 cycle after the product.
- out_valid rises 3 edges after the edge accepting the last tap (DRAIN, BIAS, OUT entry).
- Best-case throughput: TAPS+3 cycles per window (12 at default), with out_ready tied high.
- in_ready is a pure function of state (registered), with no combinational path from out_ready.

## Configuration
- CONV_ACC_SAT_EN defined:
  - Every accumulator add, including the bias add, saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Once clamped, further same-sign adds hold the clamp value.
- Undefined: adds wrap modulo 2^ACC_W.

## Structure
- Shared package cnn_pkg holds:
  - the state enum typedef (ACCUM/DRAIN/BIAS/OUT)
  - default widths ACT_W/WGT_W/ACC_W
  - the default BIAS constant, shared with quantization and ReLU
- One sub-module: conv_sat_add, an ACC_W signed adder.
  - Saturates when CONV_ACC_SAT_EN is defined; plain add otherwise.
  - Instantiated once; accumulate and bias steps share it through an operand mux.

## Test plan
- Unit window: 9 pairs act=1, wgt=1, in_valid continuous -> acc_out=-834 (0xFFFFFFFFFFFFFCBE), out_valid 3 cycles after the last accept.
- Mixed signs: act=-3, wgt=5 for all taps -> acc_out=-135-843=-978. in_ready=0 during DRAIN, BIAS and OUT.
- Backpressure: hold out_ready=0 for 10 cycles -> acc_out and out_valid stay stable and in_ready stays 0. A pulse of out_ready returns to ACCUM with acc=0.
- Gaps: in_valid toggled every other cycle -> same result as the unit window; tap_cnt advances only on accepts.
- Reset mid-window: rst=0 after 5 accepts -> outputs at reset values immediately. The next 9 unit pairs give -834.
- Overflow: act=65535, wgt=32767 for all 9 taps.
  - Without CONV_ACC_SAT_EN: acc_out=2146598078.
  - With it: acc_out=2147482804 (clamped at 2147483647, then -843).
